tx_frame_shifter: RTL and testbench

- Transmit-side counterpart of the receive word aligner.
- Builds the 32-bit word stream for the serializer: a training burst of sync words, then payload interleaved with periodic sync words.
- Applies a programmable bit offset across word boundaries so the receive aligner and lock logic can be exercised at any lane skew on the KC705 loopback.
- Sits between the payload source and the 32-bit serializer input.

---
 rtl/tx_frame_shifter_if.sv | 22 ++
 rtl/tx_frame_shifter.sv | 133 +++++++++++++
 tb/tb_tx_frame_shifter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_shifter_if.sv
// Payload, control and serializer-side signals of tx_frame_shifter, grouped by direction of drive.
interface tx_frame_shifter_if;
  logic        start;
  logic        bypass;
  logic [4:0]  bit_offset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] dout;
  logic        train_done;
  logic        sync_pulse;

  modport master (
    output start, bypass, bit_offset, s_data, s_valid,
    input  s_ready, dout, train_done, sync_pulse
  );

  modport slave (
    input  start, bypass, bit_offset, s_data, s_valid,
    output s_ready, dout, train_done, sync_pulse
  );
endinterface

// File: rtl/tx_frame_shifter.sv
// Sync training burst then payload with periodic sync, bit-shifted into dout (2 cycles, 1 in bypass); s_ready drops only in sync slots.
// Optional TX_PRBS_FILL_EN: empty payload slots carry PRBS-7 instead of IDLE_WORD.
module tx_frame_shifter #(
  parameter logic [31:0] SYNC_WORD   = 32'hBC3C_5A5A,
  parameter logic [31:0] IDLE_WORD   = 32'h0000_0000,
  parameter int          TRAIN_LEN   = 64,
  parameter int          SYNC_PERIOD = 256
) (
  input  logic              clk,
  input  logic              rst,
  tx_frame_shifter_if.slave bus
);

  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(SYNC_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_DATA} state_t;

  state_t        state;
  logic [TW-1:0] train_cnt;
  logic [PW-1:0] cnt;
  logic [4:0]    offset;
  logic [31:0]   fw, fw_d, dout_q;
  logic          train_done_q, sync_q;
  logic [31:0]   framed, fill_word, shifted;
  logic          is_sync, fill_slot;

  assign bus.s_ready    = ~rst & (state == ST_DATA) & (cnt != SLOT_LAST);
  assign fill_slot      = bus.s_ready & ~bus.s_valid;
  assign shifted        = 32'({fw, fw_d} >> offset);
  assign bus.dout       = dout_q;
  assign bus.train_done = train_done_q;
  assign bus.sync_pulse = sync_q;

`ifdef TX_PRBS_FILL_EN
  logic [6:0]  lfsr, lfsr_nxt;
  logic [31:0] prbs_word;

  // x^7+x^6+1, 32 steps per fill word; bit 0 is the first bit generated.
  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_word = '0;
    for (int i = 0; i < 32; i++) begin
      prbs_word[i] = lfsr_nxt[6] ^ lfsr_nxt[5];
      lfsr_nxt     = {lfsr_nxt[5:0], prbs_word[i]};
    end
  end

  assign fill_word = prbs_word;

  always_ff @(posedge clk) begin
    if (rst)                                lfsr <= 7'h7F;
    else if (state == ST_IDLE && bus.start) lfsr <= 7'h7F;
    else if (fill_slot)                     lfsr <= lfsr_nxt;
  end
`else
  assign fill_word = IDLE_WORD;
`endif

  always_comb begin
    framed  = IDLE_WORD;
    is_sync = 1'b0;
    case (state)
      ST_TRAIN: begin
        framed  = SYNC_WORD;
        is_sync = 1'b1;
      end
      ST_DATA: begin
        if (cnt == SLOT_LAST) begin
          framed  = SYNC_WORD;
          is_sync = 1'b1;
        end else if (bus.s_valid) begin
          framed = bus.s_data;
        end else begin
          framed = fill_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      train_cnt    <= '0;
      cnt          <= '0;
      offset       <= '0;
      fw           <= IDLE_WORD;
      fw_d         <= IDLE_WORD;
      dout_q       <= '0;
      train_done_q <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      fw     <= framed;
      fw_d   <= fw;
      sync_q <= is_sync;
      dout_q <= bus.bypass ? fw : shifted;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_TRAIN;
            offset    <= bus.bit_offset;
            train_cnt <= '0;
            cnt       <= '0;
          end
        end
        ST_TRAIN: begin
          if (!bus.start) begin
            state <= ST_IDLE;
          end else if (train_cnt == TRAIN_LAST) begin
            state        <= ST_DATA;
            cnt          <= '0;
            train_done_q <= 1'b1;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          // The current slot always completes, even when start has dropped.
          cnt <= (cnt == SLOT_LAST) ? '0 : cnt + 1'b1;
          if (!bus.start) begin
            state        <= ST_IDLE;
            train_done_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_shifter.sv
// Randomized bench for tx_frame_shifter: per-edge expectations from a stream-level model, checked by a separate monitor.
module tb_tx_frame_shifter;

  localparam logic [31:0] SYNC  = 32'hBC3C_5A5A;
  localparam logic [31:0] IDLEW = 32'h0000_0000;
  localparam int TL = 4;
  localparam int SP = 4;

  typedef struct {
    logic [31:0] dout;
    logic        rdy;
    logic        done;
    logic        sp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frame_shifter_if bus();

  tx_frame_shifter #(
    .SYNC_WORD(SYNC), .IDLE_WORD(IDLEW), .TRAIN_LEN(TL), .SYNC_PERIOD(SP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sbq[$];
  logic [31:0] pq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Stream-level model: m_t counts words framed since the start edge.
  bit          m_active;
  int          m_t;
  logic [4:0]  m_off;
  logic [31:0] m_f1, m_f2;
  int          m_prbs_idx;
  bit          prbs_seq[127];

  initial begin
    bit ext[134];
    for (int i = 0; i < 7; i++) ext[i] = 1'b1;
    for (int n = 7; n < 134; n++) ext[n] = ext[n-7] ^ ext[n-6];
    for (int k = 0; k < 127; k++) prbs_seq[k] = ext[k+7];
  end

  task automatic model_edge(input logic r, input logic st, input logic byp, input logic [4:0] off,
                            input logic vld, input logic [31:0] dat, output bit accepted);
    exp_t        e;
    logic [31:0] w;
    logic [63:0] cat;
    accepted = 1'b0;
    if (r) begin
      m_active = 1'b0; m_t = 0; m_off = '0; m_f1 = IDLEW; m_f2 = IDLEW; m_prbs_idx = 0;
      e.dout = '0; e.rdy = 1'b0; e.done = 1'b0; e.sp = 1'b0;
      sbq.push_back(e);
      return;
    end
    cat = {m_f1, m_f2};
    for (int i = 0; i < 32; i++) e.dout[i] = cat[i + int'(m_off)];
    if (byp) e.dout = m_f1;
    e.sp = 1'b0;
    w = IDLEW;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1; m_t = 0; m_off = off; m_prbs_idx = 0;
      end
    end else begin
      if (m_t < TL || ((m_t - TL) % SP) == SP - 1) begin
        w = SYNC; e.sp = 1'b1;
      end else if (vld) begin
        w = dat; accepted = 1'b1;
      end else begin
`ifdef TX_PRBS_FILL_EN
        for (int i = 0; i < 32; i++) w[i] = prbs_seq[(m_prbs_idx + i) % 127];
        m_prbs_idx = (m_prbs_idx + 32) % 127;
`else
        w = IDLEW;
`endif
      end
      m_t++;
      if (!st) m_active = 1'b0;
    end
    m_f2 = m_f1;
    m_f1 = w;
    e.done = m_active && m_t >= TL;
    e.rdy  = m_active && m_t >= TL && ((m_t - TL) % SP) != SP - 1;
    sbq.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic st, input logic byp, input logic [4:0] off, input logic vld);
    bit          acc;
    logic [31:0] d;
    @(negedge clk);
    if (pq.size() == 0) pq.push_back($urandom);
    d = pq[0];
    rst            = r;
    bus.start      = st;
    bus.bypass     = byp;
    bus.bit_offset = off;
    bus.s_valid    = vld;
    bus.s_data     = vld ? d : $urandom;
    model_edge(r, st, byp, off, vld, d, acc);
    if (acc) void'(pq.pop_front());
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("dout", bus.dout, e.dout);
        check("s_ready", 32'(bus.s_ready), 32'(e.rdy));
        check("train_done", 32'(bus.train_done), 32'(e.done));
        check("sync_pulse", 32'(bus.sync_pulse), 32'(e.sp));
      end
    end
  end

  initial begin
    logic       byp;
    logic [4:0] off;
    bus.start = 1'b0; bus.bypass = 1'b0; bus.bit_offset = '0; bus.s_valid = 1'b0; bus.s_data = '0;

    repeat (3) cycle(1, 0, 0, 0, 0);
    // Training in bypass, then payload 1..6 across a sync slot.
    pq.delete();
    for (int i = 1; i <= 6; i++) pq.push_back(32'(i));
    repeat (14) cycle(0, 1, 1, 0, 1);
    repeat (2) cycle(0, 0, 1, 0, 0);
    // Offset 8 straddling two consecutive payload words.
    pq.delete();
    pq.push_back(32'h1122_3344);
    pq.push_back(32'h5566_7788);
    repeat (10) cycle(0, 1, 0, 8, 1);
    // Offset change while in DATA only takes effect after a restart.
    cycle(0, 0, 0, 0, 0);
    repeat (8) cycle(0, 1, 0, 0, 1);
    repeat (6) cycle(0, 1, 0, 5, 1);
    cycle(0, 0, 0, 5, 0);
    repeat (8) cycle(0, 1, 0, 5, 1);
    // Empty slots carry the fill word.
    repeat (6) cycle(0, 1, 1, 5, 0);
    // Reset in the middle of DATA, then restart with start held.
    cycle(1, 1, 1, 0, 1);
    repeat (8) cycle(0, 1, 1, 0, 1);
    cycle(0, 0, 1, 0, 0);
    // Empty first slots after training, straight from a fresh start.
    repeat (10) cycle(0, 1, 1, 0, 0);

    byp = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) byp = ~byp;
      off = 5'($urandom_range(0, 31));
      cycle(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 15) != 0),
            byp, off, logic'($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #3;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
